// File: rtl/hazard_ctrl.sv
// Hazard unit: EX/ID forwarding, load-use/branch/mul-div stalls.
// Optional stall counter enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    input  logic        use_rs_id,
    input  logic        use_rt_id,
    input  logic        branch_id,
    input  logic [1:0]  md_id,
    input  logic [4:0]  rs_ex,
    input  logic [4:0]  rt_ex,
    input  logic [4:0]  dst_ex,
    input  logic [4:0]  dst_mem,
    input  logic [4:0]  dst_wb,
    input  logic        RegWrite_ex,
    input  logic        RegWrite_mem,
    input  logic        RegWrite_wb,
    input  logic [1:0]  MemtoReg_ex,
    input  logic [1:0]  MemtoReg_mem,
    output logic        stall,
    output logic        flush_ex,
    output logic [1:0]  fwd_a_ex,
    output logic [1:0]  fwd_b_ex,
    output logic        fwd_a_id,
    output logic        fwd_b_id,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    function automatic logic hit(input logic [4:0] dst,
                                 input logic       we,
                                 input logic [4:0] r);
        return we && (dst != 5'd0) && (dst == r);
    endfunction

    logic a_mem, a_wb, b_mem, b_wb;
    logic rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
    logic mem_load, load_use, br_haz, md_haz, issue;

    assign a_mem = hit(dst_mem, RegWrite_mem, rs_ex);
    assign a_wb  = hit(dst_wb, RegWrite_wb, rs_ex);
    assign b_mem = hit(dst_mem, RegWrite_mem, rt_ex);
    assign b_wb  = hit(dst_wb, RegWrite_wb, rt_ex);

    // MEM is the younger producer, so it wins over WB
    always_comb begin
        fwd_a_ex = 2'b00;
        fwd_b_ex = 2'b00;
        if (a_mem)     fwd_a_ex = 2'b01;
        else if (a_wb) fwd_a_ex = 2'b10;
        if (b_mem)     fwd_b_ex = 2'b01;
        else if (b_wb) fwd_b_ex = 2'b10;
    end

    assign rs_ex_hit  = use_rs_id && hit(dst_ex, RegWrite_ex, rs_id);
    assign rt_ex_hit  = use_rt_id && hit(dst_ex, RegWrite_ex, rt_id);
    assign rs_mem_hit = use_rs_id && hit(dst_mem, RegWrite_mem, rs_id);
    assign rt_mem_hit = use_rt_id && hit(dst_mem, RegWrite_mem, rt_id);
    assign mem_load   = (MemtoReg_mem == 2'b01);

    assign fwd_a_id = branch_id && rs_mem_hit && !mem_load;
    assign fwd_b_id = branch_id && rt_mem_hit && !mem_load;

    assign load_use = (MemtoReg_ex == 2'b01) && (rs_ex_hit || rt_ex_hit);
    assign br_haz   = branch_id &&
                      (rs_ex_hit || rt_ex_hit ||
                       (mem_load && (rs_mem_hit || rt_mem_hit)));
    assign md_haz   = (md_id != 2'b00) && md_busy;

    assign stall    = load_use || br_haz || md_haz;
    assign flush_ex = stall;

    assign md_busy = (state == BUSY);
    assign issue   = !stall && (md_id == 2'b01 || md_id == 2'b10);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (issue)
            cnt_nxt = (md_id == 2'b01) ? CW'(MULT_CYCLES)
                                       : CW'(DIV_CYCLES);
        else if (cnt != '0)
            cnt_nxt = cnt - CW'(1);
        state_nxt = (cnt_nxt != '0) ? BUSY : IDLE;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            perf_q <= '0;
        else if (stall && (perf_q != 32'hFFFF_FFFF))
            perf_q <= perf_q + 32'd1;
    end

    assign stall_cnt = perf_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Expected stall_cnt follows HAZARD_PERF_EN.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_id, rt_id, rs_ex, rt_ex;
    logic [4:0]  dst_ex, dst_mem, dst_wb;
    logic        use_rs_id, use_rt_id, branch_id;
    logic [1:0]  md_id;
    logic        RegWrite_ex, RegWrite_mem, RegWrite_wb;
    logic [1:0]  MemtoReg_ex, MemtoReg_mem;
    logic        stall, flush_ex, fwd_a_id, fwd_b_id, md_busy;
    logic [1:0]  fwd_a_ex, fwd_b_ex;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    int exp_sc = 0;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .rs_id(rs_id), .rt_id(rt_id),
        .use_rs_id(use_rs_id), .use_rt_id(use_rt_id),
        .branch_id(branch_id), .md_id(md_id),
        .rs_ex(rs_ex), .rt_ex(rt_ex),
        .dst_ex(dst_ex), .dst_mem(dst_mem), .dst_wb(dst_wb),
        .RegWrite_ex(RegWrite_ex), .RegWrite_mem(RegWrite_mem),
        .RegWrite_wb(RegWrite_wb),
        .MemtoReg_ex(MemtoReg_ex), .MemtoReg_mem(MemtoReg_mem),
        .stall(stall), .flush_ex(flush_ex),
        .fwd_a_ex(fwd_a_ex), .fwd_b_ex(fwd_b_ex),
        .fwd_a_id(fwd_a_id), .fwd_b_id(fwd_b_id),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    task automatic clear_inputs();
        rs_id = 0; rt_id = 0; use_rs_id = 0; use_rt_id = 0;
        branch_id = 0; md_id = 0; rs_ex = 0; rt_ex = 0;
        dst_ex = 0; dst_mem = 0; dst_wb = 0;
        RegWrite_ex = 0; RegWrite_mem = 0; RegWrite_wb = 0;
        MemtoReg_ex = 0; MemtoReg_mem = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        tick();
        reset = 1'b1;
        exp_sc = 0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        #2;
        checks++;
        if (md_busy !== 1'b0 || stall_cnt !== 32'd0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_state busy=%b cnt=%0d stall=%b want 0 0 0",
                     md_busy, stall_cnt, stall);
        end
        rs_ex = 5; dst_mem = 5; RegWrite_mem = 1;
        #1;
        checks++;
        if (fwd_a_ex !== 2'b01) begin
            errors++;
            $display("FAIL reset_comb_fwd got=%b want=01", fwd_a_ex);
        end
        tick();
        reset = 1'b1;
        clear_inputs();
        #1;
    endtask

    task automatic test_forward();
        do_reset();
        rs_ex = 5; rt_ex = 5;
        dst_mem = 5; dst_wb = 5; RegWrite_mem = 1; RegWrite_wb = 1;
        #1;
        checks++;
        if (fwd_a_ex !== 2'b01 || fwd_b_ex !== 2'b01) begin
            errors++;
            $display("FAIL fwd_mem_prio got=%b/%b want=01/01", fwd_a_ex, fwd_b_ex);
        end
        RegWrite_mem = 0;
        #1;
        checks++;
        if (fwd_a_ex !== 2'b10 || fwd_b_ex !== 2'b10) begin
            errors++;
            $display("FAIL fwd_wb got=%b/%b want=10/10", fwd_a_ex, fwd_b_ex);
        end
        RegWrite_mem = 1; rs_ex = 0; rt_ex = 0; dst_mem = 0; dst_wb = 0;
        #1;
        checks++;
        if (fwd_a_ex !== 2'b00 || fwd_b_ex !== 2'b00) begin
            errors++;
            $display("FAIL fwd_r0 got=%b/%b want=00/00", fwd_a_ex, fwd_b_ex);
        end
        rs_ex = 7; rt_ex = 3; dst_mem = 3; dst_wb = 7;
        #1;
        checks++;
        if (fwd_a_ex !== 2'b10 || fwd_b_ex !== 2'b01) begin
            errors++;
            $display("FAIL fwd_mixed got=%b/%b want=10/01", fwd_a_ex, fwd_b_ex);
        end
        clear_inputs();
        #1;
    endtask

    task automatic test_load_use();
        do_reset();
        MemtoReg_ex = 2'b01; dst_ex = 8; RegWrite_ex = 1;
        rs_id = 8; use_rs_id = 0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL lu_unused got=%b want=0", stall);
        end
        use_rs_id = 1;
        #1;
        checks++;
        if (stall !== 1'b1 || flush_ex !== 1'b1) begin
            errors++;
            $display("FAIL lu_stall got=%b/%b want=1/1", stall, flush_ex);
        end
        tick();
        exp_sc++;
        MemtoReg_ex = 0; dst_ex = 0; RegWrite_ex = 0;
        MemtoReg_mem = 2'b01; dst_mem = 8; RegWrite_mem = 1;
        #1;
        checks++;
        if (stall !== 1'b0 || flush_ex !== 1'b0) begin
            errors++;
            $display("FAIL lu_release got=%b/%b want=0/0", stall, flush_ex);
        end
        tick();
        use_rs_id = 0; rs_id = 0; rs_ex = 8;
        MemtoReg_mem = 0; dst_mem = 0; RegWrite_mem = 0;
        dst_wb = 8; RegWrite_wb = 1;
        #1;
        checks++;
        if (fwd_a_ex !== 2'b10) begin
            errors++;
            $display("FAIL lu_fwd got=%b want=10", fwd_a_ex);
        end
        checks++;
        if (stall_cnt !== (PERF ? 32'(exp_sc) : 32'd0)) begin
            errors++;
            $display("FAIL lu_stall_cnt got=%0d want=%0d",
                     stall_cnt, PERF ? exp_sc : 0);
        end
        clear_inputs();
        #1;
    endtask

    task automatic test_branch();
        do_reset();
        branch_id = 1; use_rt_id = 1; rt_id = 9;
        dst_ex = 9; RegWrite_ex = 1;
        #1;
        checks++;
        if (stall !== 1'b1 || fwd_b_id !== 1'b0) begin
            errors++;
            $display("FAIL br_ex got=%b/%b want=1/0", stall, fwd_b_id);
        end
        tick();
        exp_sc++;
        dst_ex = 0; RegWrite_ex = 0; dst_mem = 9; RegWrite_mem = 1;
        #1;
        checks++;
        if (stall !== 1'b0 || fwd_b_id !== 1'b1 || fwd_a_id !== 1'b0) begin
            errors++;
            $display("FAIL br_mem_alu got=%b/%b/%b want=0/1/0",
                     stall, fwd_b_id, fwd_a_id);
        end
        MemtoReg_mem = 2'b01;
        #1;
        checks++;
        if (stall !== 1'b1 || fwd_b_id !== 1'b0) begin
            errors++;
            $display("FAIL br_mem_load got=%b/%b want=1/0", stall, fwd_b_id);
        end
        MemtoReg_mem = 0; branch_id = 0;
        #1;
        checks++;
        if (stall !== 1'b0 || fwd_b_id !== 1'b0) begin
            errors++;
            $display("FAIL br_nobranch got=%b/%b want=0/0", stall, fwd_b_id);
        end
        clear_inputs();
        #1;
        checks++;
        if (stall_cnt !== (PERF ? 32'(exp_sc) : 32'd0)) begin
            errors++;
            $display("FAIL br_stall_cnt got=%0d want=%0d",
                     stall_cnt, PERF ? exp_sc : 0);
        end
    endtask

    task automatic test_md();
        int bad;
        do_reset();
        md_id = 2'b10;
        #1;
        checks++;
        if (stall !== 1'b0 || md_busy !== 1'b0) begin
            errors++;
            $display("FAIL div_issue got=%b/%b want=0/0", stall, md_busy);
        end
        tick();
        md_id = 2'b11;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (md_busy !== 1'b1 || stall !== 1'b1) bad++;
            tick();
            exp_sc++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL div_busy10 bad_cycles=%0d want=0", bad);
        end
        #1;
        checks++;
        if (md_busy !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL div_done got=%b/%b want=0/0", md_busy, stall);
        end
        md_id = 2'b01;
        tick();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (md_busy !== 1'b1 || stall !== 1'b1) bad++;
            tick();
            exp_sc++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mult_busy5 bad_cycles=%0d want=0", bad);
        end
        #1;
        checks++;
        if (md_busy !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL mult_held_release got=%b/%b want=0/0", md_busy, stall);
        end
        tick();
        md_id = 2'b00;
        #1;
        checks++;
        if (md_busy !== 1'b1) begin
            errors++;
            $display("FAIL mult_held_issue got=%b want=1", md_busy);
        end
        checks++;
        if (stall_cnt !== (PERF ? 32'(exp_sc) : 32'd0)) begin
            errors++;
            $display("FAIL md_stall_cnt got=%0d want=%0d",
                     stall_cnt, PERF ? exp_sc : 0);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        do_reset();
        md_id = 2'b01;
        tick();
        md_id = 2'b11;
        tick();
        exp_sc++;
        tick();
        exp_sc++;
        reset = 1'b0;
        #1;
        checks++;
        if (md_busy !== 1'b0 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid got=%b/%0d want=0/0", md_busy, stall_cnt);
        end
        md_id = 0; MemtoReg_ex = 2'b01; dst_ex = 4; RegWrite_ex = 1;
        rt_id = 4; use_rt_id = 1;
        #1;
        checks++;
        if (stall !== 1'b1 || flush_ex !== 1'b1) begin
            errors++;
            $display("FAIL rst_comb_stall got=%b/%b want=1/1", stall, flush_ex);
        end
        clear_inputs();
        md_id = 2'b11;
        tick();
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (md_busy !== 1'b0 || stall !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_no_residual bad_cycles=%0d want=0", bad);
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_md();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: EX-stage busy cycles after a multiply issues.
REQ-002 Parameter DIV_CYCLES, default 10: EX-stage busy cycles after a divide issues.
REQ-003 clk  in  1  the single pipeline clock; all state changes on posedge.
REQ-004 reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-005 rs_id, rt_id  in  5 each  source registers of the instruction in ID.
REQ-006 use_rs_id, use_rt_id  in  1 each  the ID instruction reads rs / rt.
REQ-007 branch_id  in  1  the ID instruction is a branch or jr that compares or uses operands in ID.
REQ-008 md_id  in  2  00 none, 01 mult, 10 div, 11 mfhi/mflo/mthi/mtlo.
REQ-009 rs_ex, rt_ex  in  5 each  sources of the instruction in EX.
REQ-010 dst_ex, dst_mem, dst_wb  in  5 each  resolved write register per stage.
REQ-011 RegWrite_ex, RegWrite_mem, RegWrite_wb  in  1 each  the stage writes the register file.
REQ-012 MemtoReg_ex, MemtoReg_mem  in  2 each  2'b01 means a load from data memory.
REQ-013 stall  out  1  freeze PC and IF/ID.
REQ-014 flush_ex  out  1  insert a bubble into ID/EX next edge.
REQ-015 fwd_a_ex, fwd_b_ex  out  2 each  EX operand select: 00 regfile, 01 MEM result, 10 WB result.
REQ-016 fwd_a_id, fwd_b_id  out  1 each  ID branch operand select: 1 means MEM ALU result.
REQ-017 md_busy  out  1  multiply/divide unit busy.
REQ-018 stall_cnt  out  32  count of stalled cycles.

Function
REQ-019 A register match requires nonzero dst, RegWrite set and equal register number; $0 shall never match.
REQ-020 fwd_a_ex shall be 01 on a MEM match with rs_ex, else 10 on a WB match, else 00; fwd_b_ex likewise with rt_ex. MEM has priority.
REQ-021 fwd_a_id/fwd_b_id shall be 1 only when branch_id is set and the used rs_id/rt_id matches MEM and MemtoReg_mem is not 01.
REQ-022 Load-use: stall when MemtoReg_ex is 01 and dst_ex matches a used ID source.
REQ-023 Branch hazard: stall when branch_id is set and a used source matches EX (any type) or matches MEM with MemtoReg_mem 01.
REQ-024 MD hazard: stall when md_id is nonzero and md_busy is 1.
REQ-025 stall is the OR of REQ-022 to REQ-024; flush_ex shall equal stall; both are combinational with zero latency.
REQ-026 The MD FSM shall have states IDLE and BUSY with a down-counter of width clog2(DIV_CYCLES+1).
REQ-027 On a posedge with md_id 01 or 10 and stall 0, the counter shall load MULT_CYCLES or DIV_CYCLES respectively.
REQ-028 Otherwise a nonzero counter shall decrement by 1; md_busy = (counter != 0), so busy lasts exactly N cycles after the issue edge.
REQ-029 A mult/div held by stall shall not load the counter; it issues on the first cycle after md_busy drops.
REQ-030 stall_cnt shall increment on each posedge where stall is 1 and saturate at 32'hFFFFFFFF.

Reset
REQ-031 While reset is 0: counter 0, md_busy 0, stall_cnt 0, FSM IDLE; stall, flush_ex and forwards follow inputs combinationally.
REQ-032 Reset asserted mid multiply/divide shall abort the operation immediately, with no residual busy after release.

Configuration
REQ-033 With HAZARD_PERF_EN defined, stall_cnt shall behave per REQ-030.
REQ-034 Without HAZARD_PERF_EN, stall_cnt shall be constant 0 and its register shall not exist; all other behaviour is unchanged.

Verification
REQ-035 lw $8 in EX (MemtoReg_ex 01, dst_ex 8), ID add uses rs=8 -> stall=1 and flush_ex=1 for one cycle; next cycle fwd_a_ex=10.
REQ-036 dst_mem=5 and dst_wb=5, both writing, rs_ex=5 -> fwd_a_ex=01; same case with dst=0 -> fwd_a_ex=00.
REQ-037 beq in ID uses rt=9, EX writes 9 -> stall 1 cycle; next cycle with 9 in MEM as ALU result -> fwd_b_id=1 and stall=0.
REQ-038 div issues, then mfhi in ID -> md_busy high for exactly 10 cycles, stall high for those 10, mfhi proceeds on the 11th cycle.
REQ-039 reset pulsed low during cycle 3 of a mult -> md_busy=0 at once and stall_cnt=0; with HAZARD_PERF_EN undefined, stall_cnt stays 0 throughout REQ-035.
